// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with valid/ready handshakes on operand and
// result sides. Add/sub/logic/compare finish in one cycle; shifts use a
// one-bit-per-cycle serial shifter by default.
// Build option: define ALU_BARREL_SHIFT_EN to compute shifts combinationally
// (latency 1, SHIFT state never entered, busy tied low, no accumulator/counter).
module alu_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam int SW = $clog2(XLEN);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  localparam logic [XLEN-1:0] XZERO = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] XONE  = {{(XLEN-1){1'b0}}, 1'b1};

  // Single-cycle datapath; unused codes (1010-1111) fall through to ADD.
  function automatic logic [XLEN-1:0] alu_comb(
    input logic [3:0]      ctl,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic [XLEN-1:0] r;
`ifdef ALU_BARREL_SHIFT_EN
    logic [SW-1:0] sh;
    sh = b[SW-1:0];
`endif
    case (ctl)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = ($signed(a) < $signed(b)) ? XONE : XZERO;
      OP_SLTU: r = (a < b) ? XONE : XZERO;
`ifdef ALU_BARREL_SHIFT_EN
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $unsigned($signed(a) >>> sh);
`endif
      default: r = a + b;
    endcase
    return r;
  endfunction

  logic [1:0]      state_r;
  logic [1:0]      state_n_s;
  logic [XLEN-1:0] result_r;
  logic [XLEN-1:0] result_n_s;
  logic            zero_r;
  logic            zero_n_s;
  logic            out_valid_r;
  logic            in_ready_s;
  logic            accept_s;
  logic [XLEN-1:0] alu_res_s;

`ifndef ALU_BARREL_SHIFT_EN
  localparam logic [SW-1:0] CNT_ZERO = {SW{1'b0}};
  localparam logic [SW-1:0] CNT_ONE  = {{(SW-1){1'b0}}, 1'b1};

  // One step of the serial shifter for the latched shift kind.
  function automatic logic [XLEN-1:0] shift_one(
    input logic [XLEN-1:0] acc,
    input logic [3:0]      sop
  );
    logic [XLEN-1:0] r;
    case (sop)
      OP_SLL:  r = {acc[XLEN-2:0], 1'b0};
      OP_SRL:  r = {1'b0, acc[XLEN-1:1]};
      OP_SRA:  r = {acc[XLEN-1], acc[XLEN-1:1]};
      default: r = acc;
    endcase
    return r;
  endfunction

  logic [XLEN-1:0] acc_r;
  logic [XLEN-1:0] acc_n_s;
  logic [XLEN-1:0] acc_shift_s;
  logic [SW-1:0]   cnt_r;
  logic [SW-1:0]   cnt_n_s;
  logic [3:0]      sop_r;
  logic [3:0]      sop_n_s;
  logic            busy_r;
  logic            is_shift_s;
  logic [SW-1:0]   shamt_s;

  assign is_shift_s  = (alu_ctl == OP_SLL) || (alu_ctl == OP_SRL) || (alu_ctl == OP_SRA);
  assign shamt_s     = op_b[SW-1:0];
  assign acc_shift_s = shift_one(acc_r, sop_r);
`endif

  assign in_ready_s = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
  assign accept_s   = in_valid && in_ready_s;
  assign alu_res_s  = alu_comb(alu_ctl, op_a, op_b);

  // Next-state, result and shifter-register selection.
  always_comb begin
    state_n_s  = state_r;
    result_n_s = result_r;
    zero_n_s   = zero_r;
`ifndef ALU_BARREL_SHIFT_EN
    acc_n_s    = acc_r;
    cnt_n_s    = cnt_r;
    sop_n_s    = sop_r;
`endif
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
`ifndef ALU_BARREL_SHIFT_EN
          if (is_shift_s) begin
            acc_n_s = op_a;
            cnt_n_s = shamt_s;
            sop_n_s = alu_ctl;
            if (shamt_s == CNT_ZERO) begin
              result_n_s = op_a;
              zero_n_s   = (op_a == XZERO);
              state_n_s  = ST_DONE;
            end else begin
              state_n_s  = ST_SHIFT;
            end
          end else begin
            result_n_s = alu_res_s;
            zero_n_s   = (alu_res_s == XZERO);
            state_n_s  = ST_DONE;
          end
`else
          result_n_s = alu_res_s;
          zero_n_s   = (alu_res_s == XZERO);
          state_n_s  = ST_DONE;
`endif
        end else if ((state_r == ST_DONE) && out_ready) begin
          state_n_s = ST_IDLE;
        end else begin
          state_n_s = state_r;
        end
      end
`ifndef ALU_BARREL_SHIFT_EN
      ST_SHIFT: begin
        // The k-th shift lands straight in result, so a shift by k is
        // visible k+1 cycles after accept and SHIFT lasts k cycles.
        acc_n_s = acc_shift_s;
        cnt_n_s = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          result_n_s = acc_shift_s;
          zero_n_s   = (acc_shift_s == XZERO);
          state_n_s  = ST_DONE;
        end else begin
          state_n_s  = ST_SHIFT;
        end
      end
`endif
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // Control state and registered result/flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      result_r    <= XZERO;
      zero_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      result_r    <= result_n_s;
      zero_r      <= zero_n_s;
      out_valid_r <= (state_n_s == ST_DONE);
    end
  end

`ifndef ALU_BARREL_SHIFT_EN
  // Serial shifter accumulator, remaining-count and shift kind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r  <= XZERO;
      cnt_r  <= CNT_ZERO;
      sop_r  <= OP_ADD;
      busy_r <= 1'b0;
    end else begin
      acc_r  <= acc_n_s;
      cnt_r  <= cnt_n_s;
      sop_r  <= sop_n_s;
      busy_r <= (state_n_s == ST_SHIFT);
    end
  end

  assign busy = busy_r;
`else
  assign busy = 1'b0;
`endif

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign zero      = zero_r;

endmodule
